// File: rtl/caliptra_prim_fifo_wr_arb.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among NumReq requesters.
// Latency: 1-cycle grant bubble in IDLE, then beats pass combinationally to the FIFO.
// Backpressure: fifo_wready_i low stalls the owner (ready=0) with no state change.
module caliptra_prim_fifo_wr_arb #(
    parameter  int NumReq   = 4,
    parameter  int Width    = 32,
    parameter  int MaxBeats = 16,
    localparam int IdW      = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int CntW     = (MaxBeats > 1) ? $clog2(MaxBeats) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    input  logic [NumReq-1:0]       req_last_i,
    input  logic [NumReq*Width-1:0] req_data_i,
    output logic                    fifo_wvalid_o,
    input  logic                    fifo_wready_i,
    output logic [IdW+Width-1:0]    fifo_wdata_o,
    output logic [NumReq-1:0]       grant_o,
    output logic                    busy_o,
    output logic                    err_o
);

    typedef enum logic {IDLE, BURST} state_e;

    state_e            state;
    logic [IdW-1:0]    rr_ptr;
    logic [IdW-1:0]    owner;
    logic [CntW-1:0]   beat_cnt;
    logic [NumReq-1:0] grant;
    logic              err;

    logic              any_valid;
    logic [IdW-1:0]    winner;
    logic [IdW-1:0]    scan_idx;
    logic              busy;
    logic              own_valid;
    logic              own_last;
    logic [Width-1:0]  own_data;
    logic              accept;
    logic              wd_hit;

    // Round-robin scan starting at rr_ptr; walking backwards lets the closest candidate win last.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        scan_idx  = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            scan_idx = IdW'((int'(rr_ptr) + k) % NumReq);
            if (req_valid_i[scan_idx]) begin
                any_valid = 1'b1;
                winner    = scan_idx;
            end
        end
    end

    assign busy      = (state == BURST);
    assign own_valid = req_valid_i[owner];
    assign own_last  = req_last_i[owner];
    assign own_data  = req_data_i[int'(owner)*Width +: Width];
    assign accept    = busy & ~clr_i & own_valid & fifo_wready_i;
    assign wd_hit    = (beat_cnt == CntW'(MaxBeats - 1));

    // Only the owner's lane reaches the FIFO; clear suppresses the handshake in its cycle.
    assign fifo_wvalid_o = busy & ~clr_i & own_valid;
    assign req_ready_o   = (busy & ~clr_i & fifo_wready_i) ? grant : '0;
    assign fifo_wdata_o  = busy ? {owner, own_data} : '0;
    assign grant_o       = grant;
    assign busy_o        = busy;
    assign err_o         = err;

    // Arbitration FSM: grant in IDLE, count beats in BURST, release on last or watchdog.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            grant    <= '0;
            err      <= 1'b0;
        end else if (clr_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            grant    <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state    <= BURST;
                        owner    <= winner;
                        grant    <= NumReq'(1) << winner;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (accept) begin
                        if (own_last || wd_hit) begin
                            state    <= IDLE;
                            grant    <= '0;
                            beat_cnt <= '0;
                            rr_ptr   <= (owner == IdW'(NumReq - 1)) ? '0 : owner + IdW'(1);
                            // A forced release leaves the rest of the packet to re-arbitrate.
                            if (!own_last) begin
                                err <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CntW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_caliptra_prim_fifo_wr_arb.sv
// Randomized bench for caliptra_prim_fifo_wr_arb with a queue-based reference model.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after each edge.
// Directed phases cover single requester, contention, clear, watchdog and async reset.
module tb_caliptra_prim_fifo_wr_arb;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int MB  = 4;
    localparam int IdW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [N-1:0]     valid;
    logic [N-1:0]     ready;
    logic [N-1:0]     last;
    logic [N*W-1:0]   data;
    logic             wvalid;
    logic             wready;
    logic [IdW+W-1:0] wdata;
    logic [N-1:0]     grant;
    logic             busy;
    logic             err;

    always #5 clk = ~clk;

    caliptra_prim_fifo_wr_arb #(.NumReq(N), .Width(W), .MaxBeats(MB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clr_i        (clr),
        .req_valid_i  (valid),
        .req_ready_o  (ready),
        .req_last_i   (last),
        .req_data_i   (data),
        .fifo_wvalid_o(wvalid),
        .fifo_wready_i(wready),
        .fifo_wdata_o (wdata),
        .grant_o      (grant),
        .busy_o       (busy),
        .err_o        (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Per-requester packet queues: {last, data}
    logic [W:0] mem [N][64];
    int hd [N];
    int tl [N];

    // Reference model: owner index (-1 when idle), pointer, beat count, sticky error
    int m_owner, m_ptr, m_cnt;
    bit m_err;

    // Stimulus knobs
    int p_valid, p_wr, p_clr, min_len, max_len;
    bit refill;

    // Observations
    int tag1_beats = 0;
    logic [N-1:0] grant_log[$];
    logic [N-1:0] prev_grant = '0;

    task automatic load(input int i, input int len);
        if (hd[i] == tl[i]) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        for (int b = 0; b < len; b++) begin
            mem[i][tl[i]] = {(b == len - 1), W'($urandom())};
            tl[i]++;
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_err   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  64'(ready),  64'(0));
        check({tag, "_wvalid"}, 64'(wvalid), 64'(0));
        check({tag, "_wdata"},  64'(wdata),  64'(0));
        check({tag, "_grant"},  64'(grant),  64'(0));
        check({tag, "_busy"},   64'(busy),   64'(0));
        check({tag, "_err"},    64'(err),    64'(0));
    endtask

    task automatic cycle();
        logic             e_wv;
        logic [N-1:0]     e_rdy;
        logic [IdW+W-1:0] e_wd;
        logic [N-1:0]     e_grant;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (refill && hd[i] == tl[i]) load(i, $urandom_range(max_len, min_len));
            if (hd[i] != tl[i]) begin
                valid[i] = ($urandom_range(99, 0) < p_valid);
                {last[i], data[i*W +: W]} = mem[i][hd[i]];
            end else begin
                valid[i] = 1'b0;
                last[i]  = 1'($urandom());
                data[i*W +: W] = W'($urandom());
            end
        end
        wready = ($urandom_range(99, 0) < p_wr);
        clr    = ($urandom_range(99, 0) < p_clr);
        #1;
        e_wv = 1'b0;
        e_rdy = '0;
        e_wd = '0;
        if (m_owner >= 0) begin
            e_wd = {IdW'(m_owner), data[m_owner*W +: W]};
            if (!clr) begin
                e_wv = valid[m_owner];
                e_rdy[m_owner] = wready;
            end
        end
        check("wvalid", 64'(wvalid), 64'(e_wv));
        check("ready",  64'(ready),  64'(e_rdy));
        check("wdata",  64'(wdata),  64'(e_wd));
        if (wvalid && wready && wdata[W +: IdW] == IdW'(1)) tag1_beats++;
        // Next-state of the reference model
        if (clr) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_cnt   = 0;
                end
            end
        end else if (valid[m_owner] && wready) begin
            hd[m_owner]++;
            if (last[m_owner] || m_cnt + 1 == MB) begin
                if (!last[m_owner]) m_err = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
        check("grant", 64'(grant), 64'(e_grant));
        check("busy",  64'(busy),  64'(m_owner >= 0));
        check("err",   64'(err),   64'(m_err));
        if (prev_grant == '0 && grant != '0) grant_log.push_back(grant);
        prev_grant = grant;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        valid = '0;
        last = '0;
        data = '0;
        wready = 1'b0;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        model_reset();
        refill = 1'b0;
        p_valid = 100; p_wr = 100; p_clr = 0; min_len = 1; max_len = 1;

        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single requester: req1, 3 beats, FIFO always ready
        load(1, 3);
        repeat (8) cycle();
        check("tag1_beats", 64'(tag1_beats), 64'(3));
        check("single_grants", 64'(grant_log.size()), 64'(1));
        if (grant_log.size() > 0) check("single_grant", 64'(grant_log[0]), 64'(4'b0010));

        // Clear pulse resets the round-robin pointer
        p_clr = 100;
        cycle();
        p_clr = 0;

        // Contention: all requesters with 2-beat packets
        grant_log.delete();
        refill = 1'b1; min_len = 2; max_len = 2;
        repeat (30) cycle();
        check("rr_count", 64'(grant_log.size() >= 5), 64'(1));
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            check("rr_order", 64'(grant_log[k]), 64'(N'(1) << (k % N)));

        // Random traffic with backpressure, clears and over-long packets
        min_len = 1; max_len = 6;
        p_valid = 75; p_wr = 70; p_clr = 2;
        repeat (3000) cycle();

        // Async reset asserted mid-burst between clock edges
        p_valid = 100; p_wr = 100; p_clr = 0;
        for (int t = 0; t < 20 && m_owner < 0; t++) cycle();
        check("reached_busy", 64'(m_owner >= 0), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_grant = '0;
        grant_log.delete();
        repeat (5) cycle();
        check("post_rst_grants", 64'(grant_log.size() > 0), 64'(1));
        if (grant_log.size() > 0) check("post_rst_grant", 64'(grant_log[0]), 64'(4'b0001));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/caliptra_prim_fifo_wr_arb.md
Name: caliptra_prim_fifo_wr_arb

Overview:
- Round-robin, packet-locked write arbiter that shares one caliptra_prim_fifo_sync write port among NumReq requesters.
- Each requester presents beats with valid/ready/last; once granted, a requester owns the FIFO until its last beat is accepted.
- A MaxBeats watchdog bounds ownership.
- Each beat is tagged with the source index so the FIFO consumer can demultiplex.

Parameters:
- NumReq, 4, number of requesters (>=2).
- Width, 32, per-requester data width.
- MaxBeats, 16, maximum beats per packet before forced release (>=1).
- IdW, derived, vbits(NumReq); tag width.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- clr_i  input  1  synchronous clear; aborts any burst
- req_valid_i  input  NumReq  per-requester beat valid
- req_ready_o  output  NumReq  per-requester beat accepted
- req_last_i  input  NumReq  per-requester last beat of packet
- req_data_i  input  NumReq*Width  packed beat data; requester i occupies bits [i*Width +: Width]
- fifo_wvalid_o  output  1  to FIFO wvalid_i
- fifo_wready_i  input  1  from FIFO wready_o
- fifo_wdata_o  output  IdW+Width  {grant index, data} to FIFO wdata_i
- grant_o  output  NumReq  one-hot current owner; 0 when idle
- busy_o  output  1  burst in progress
- err_o  output  1  sticky; set on watchdog release

Behaviour:
- Reset (rst_i high, async): state=IDLE, rr_ptr=0, beat_cnt=0, grant=0, err_o=0.
  - All outputs are 0 during reset: req_ready_o, fifo_wvalid_o, fifo_wdata_o, grant_o, busy_o.
- FSM IDLE:
  - Winner = first i with req_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NumReq.
  - If any valid: register grant=onehot(winner), go to BURST.
  - No beat transfers in IDLE, so grant latency is 1 cycle (bubble).
  - If no valid: stay in IDLE.
- FSM BURST (owner g):
  - fifo_wvalid_o = req_valid_i[g].
  - fifo_wdata_o = {IdW'(g), req_data_i[g]}.
  - req_ready_o[g] = fifo_wready_i; all other ready bits = 0.
  - Beat accepted when req_valid_i[g] & fifo_wready_i; beat_cnt increments on each accepted beat.
- Release: on an accepted beat with req_last_i[g]=1:
  - next state IDLE, grant=0, beat_cnt=0, rr_ptr=(g+1) mod NumReq.
- Watchdog: on an accepted beat with last=0 while beat_cnt==MaxBeats-1:
  - same release as above, and err_o set.
  - The remaining beats of that requester re-arbitrate as a new packet.
- Owner stall: a stall while owning (req_valid_i[g]=0) holds the grant indefinitely; the watchdog counts beats, not cycles.
- fifo_wready_i=0 (FIFO full or under reset): stall, with no state change.
- Ignored inputs:
  - req_last_i of non-owners is ignored.
  - req_valid_i changes by non-owners during BURST are ignored.
- clr_i (synchronous, highest priority):
  - next state IDLE, grant=0, beat_cnt=0, rr_ptr=0, err_o cleared.
  - fifo_wvalid_o=0 and req_ready_o=0 in the clr_i cycle.
  - clr_i is driven with the same signal as the FIFO's clr_i.
- Reset mid-burst: immediate abort; the partial packet remains in the FIFO. Consumer recovery relies on the tag and last framing upstream.
- Width rules:
  - The tag is zero-extended to IdW.
  - rr_ptr wraps from NumReq-1 to 0.
  - beat_cnt width is vbits(MaxBeats).
- MaxBeats=1: every beat is a single-beat packet. err_o is set only when last=0.

Test Plan:
- Single requester: req1 sends a 3-beat packet, FIFO always ready -> grant_o=0010 one cycle after valid; 3 writes with tag=1; idle; rr_ptr=2.
- Contention: all 4 requesters hold 2-beat packets continuously -> grant order 0,1,2,3,0; no interleaving of tags within a packet; 1 idle cycle between packets.
- Backpressure: fifo_wready_i low for 5 cycles mid-packet -> fifo_wvalid_o held with stable data; beat_cnt unchanged; no ready pulses.
- Watchdog: MaxBeats=4; req2 sends 6 beats with last=0 -> release after the 4th beat; err_o=1 sticky; remaining beats re-granted as a new packet.
- clr_i mid-burst on beat 2 of 5 -> next cycle state IDLE, grant_o=0, err_o=0, rr_ptr=0; req0 wins the next arbitration.
- Async reset asserted mid-burst between clock edges -> all outputs 0 immediately; after deassert, the first grant goes to the lowest-index valid requester.
